// File: rtl/conv3x3_window_gen_pkg.sv
// Shared types for the 3x3 window generator.
// Pixel and window types used by the window generator and its bench.
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int N_TAPS     = 9;

  typedef logic signed [DATA_WIDTH-1:0] pix_t;
  typedef pix_t window_t [N_TAPS];

endpackage

// File: rtl/conv3x3_window_gen_if.sv
// Pixel-in / window-out bundle for conv3x3_window_gen.
// The master drives pixels and the stall; the slave returns windows.
interface conv3x3_window_gen_if #(
  parameter int DW = conv_pkg::DATA_WIDTH
);
  import conv_pkg::*;

  logic                 pix_valid;
  logic                 pix_ready;
  logic                 pix_sof;
  logic signed [DW-1:0] pix_data;
  logic                 stall_in;
  logic                 win_valid;
  logic                 win_last;
  logic signed [DW-1:0] win_a [N_TAPS];

  modport master (
    output pix_valid, pix_sof, pix_data, stall_in,
    input  pix_ready, win_valid, win_last, win_a
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data, stall_in,
    output pix_ready, win_valid, win_last, win_a
  );

endinterface

// File: rtl/conv3x3_window_gen_line_buffer.sv
// One image row of storage: combinational read, synchronous write.
// Reading and writing the same address in a cycle returns the old word.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv3x3_window_gen.sv
// Raster pixel stream to 3x3 activation windows for the 9-tap MAC.
// Two row buffers feed a column-shifting window; one window per interior pixel.
module conv3x3_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input logic                  clk,
  input logic                  arst_n_in,
  conv3x3_window_gen_if.slave  bus
);
  import conv_pkg::*;

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef logic signed [DATA_WIDTH-1:0] dat_t;

  logic [CW-1:0] col_q, col_d, col_e;
  logic [RW-1:0] row_q, row_d, row_e;
  dat_t          win_q [N_TAPS];
  dat_t          win_d [N_TAPS];
  dat_t          out_q [N_TAPS];
  dat_t          out_d [N_TAPS];
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          accept;

  logic [DATA_WIDTH-1:0] lb0_rd;
  logic [DATA_WIDTH-1:0] lb1_rd;

  assign bus.pix_ready = !bus.stall_in;
  assign accept        = bus.pix_valid && !bus.stall_in;

  // sof forces this pixel to (0,0) regardless of counter state
  assign col_e = bus.pix_sof ? '0 : col_q;
  assign row_e = bus.pix_sof ? '0 : row_q;

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_e),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_e),
    .wdata_i (bus.pix_data),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    out_d   = out_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    if (accept) begin
      if (col_e == COL_LAST) begin
        col_d = '0;
        row_d = (row_e == ROW_LAST) ? '0 : row_e + 1'b1;
      end else begin
        col_d = col_e + 1'b1;
        row_d = row_e;
      end
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = dat_t'(lb0_rd);
      win_d[5] = dat_t'(lb1_rd);
      win_d[8] = bus.pix_data;
      valid_d  = (row_e >= ROW_TWO) && (col_e >= COL_TWO);
      last_d   = valid_d && (row_e == ROW_LAST) && (col_e == COL_LAST);
      // outputs only move on a real window so the MAC sees stable taps
      if (valid_d) begin
        out_d = win_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) begin
        win_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < N_TAPS; i++) begin
        win_q[i] <= win_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  assign bus.win_valid = valid_q;
  assign bus.win_last  = last_q;
  assign bus.win_a     = out_q;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen on a 4x4 image.
// Frame-store reference model plus a fixed table for the plain stream.
module tb_conv3x3_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;

  typedef logic signed [DW-1:0] pix_t;

  typedef struct {
    int data;
    bit ev;
    bit el;
    int ew [9];
  } vec_t;

  logic clk = 1'b0;
  logic arst_n_in;

  always #5 clk = ~clk;

  conv3x3_window_gen_if #(.DW(DW)) bus ();

  conv3x3_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .bus       (bus)
  );

  int   nvec;
  int   nerr;
  int   pulses;
  int   mrow;
  int   mcol;
  pix_t img [H][W];
  pix_t held [9];
  bit   mlast;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // frame-store model: a window is simply the 3x3 neighbourhood ending at (r,c)
  function automatic bit model_acc(bit v, bit sof, pix_t d, bit st);
    int r;
    int c;
    bit ev = 1'b0;
    mlast = 1'b0;
    if (v && !st) begin
      r = sof ? 0 : mrow;
      c = sof ? 0 : mcol;
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            held[3*i+j] = img[r-2+i][c-2+j];
        mlast = (r == H-1) && (c == W-1);
      end
      mcol = c + 1;
      mrow = r;
      if (mcol == W) begin
        mcol = 0;
        mrow = (r + 1) % H;
      end
    end
    return ev;
  endfunction

  task automatic drive(bit v, bit sof, pix_t d, bit st);
    bus.pix_valid = v;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    bus.stall_in  = st;
  endtask

  task automatic step(bit v, bit sof, int d, bit st);
    bit ev;
    drive(v, sof, pix_t'(d), st);
    #1;
    chk("pix_ready", bus.pix_ready, !st);
    ev = model_acc(v, sof, pix_t'(d), st);
    @(posedge clk);
    #1;
    chk("win_valid", bus.win_valid, ev);
    chk("win_last", bus.win_last, mlast);
    for (int k = 0; k < 9; k++)
      chk($sformatf("win_a%0d", k), bus.win_a[k], held[k]);
    if (bus.win_valid) pulses++;
  endtask

  task automatic do_reset(int cycles);
    arst_n_in = 1'b0;
    drive(1'b1, 1'b0, pix_t'(16'h7777), 1'b0);
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      chk("rst_valid", bus.win_valid, 0);
      chk("rst_last", bus.win_last, 0);
      for (int k = 0; k < 9; k++)
        chk($sformatf("rst_a%0d", k), bus.win_a[k], 0);
    end
    arst_n_in = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0);
    mrow  = 0;
    mcol  = 0;
    mlast = 1'b0;
    for (int k = 0; k < 9; k++) held[k] = '0;
  endtask

  vec_t tbl [16];
  int   offs [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  int   pw   [9] = '{default: 0};
  int   p;
  int   sum;
  int   guard;
  bit   v;
  bit   st;
  bit   ev;

  initial begin
    nvec = 0;
    nerr = 0;
    for (int q = 0; q < 16; q++) begin
      tbl[q].data = q;
      tbl[q].ev   = (q / W >= 2) && (q % W >= 2);
      tbl[q].el   = (q == 15);
      if (tbl[q].ev)
        for (int k = 0; k < 9; k++) pw[k] = q - 10 + offs[k];
      tbl[q].ew = pw;
    end

    drive(1'b0, 1'b0, '0, 1'b0);
    do_reset(2);

    // test 1: plain stream against the fixed table
    pulses = 0;
    for (int q = 0; q < 16; q++) begin
      drive(1'b1, q == 0, pix_t'(tbl[q].data), 1'b0);
      ev = model_acc(1'b1, q == 0, pix_t'(tbl[q].data), 1'b0);
      @(posedge clk);
      #1;
      chk("t1_valid", bus.win_valid, tbl[q].ev);
      chk("t1_last", bus.win_last, tbl[q].el);
      for (int k = 0; k < 9; k++)
        chk($sformatf("t1_a%0d", k), bus.win_a[k], tbl[q].ew[k]);
      if (bus.win_valid) pulses++;
      if (q == 10) begin
        sum = 0;
        for (int k = 0; k < 9; k++) sum += int'(bus.win_a[k]);
        chk("t6_mac_sum", sum, 45);
      end
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("t1_pulses", pulses, 4);

    // test 2: stall around pixel 9 and idle gaps
    pulses = 0;
    for (int q = 0; q < 16; q++) begin
      if (q == 9)
        for (int s = 0; s < 3; s++) step(1'b1, 1'b0, 9, 1'b1);
      if (q == 5 || q == 11) step(1'b0, 1'b0, 999, 1'b0);
      step(1'b1, q == 0, q, 1'b0);
      if (q == 10) begin
        chk("t2_first_a0", bus.win_a[0], 0);
        chk("t2_first_a8", bus.win_a[8], 10);
      end
    end
    step(1'b0, 1'b0, 0, 1'b1);
    chk("t2_pulses", pulses, 4);

    // test 3: two frames with no bubble
    pulses = 0;
    for (int q = 0; q < 32; q++) begin
      step(1'b1, (q % 16) == 0, q, 1'b0);
      if (q == 26) begin
        chk("t3_f2_a0", bus.win_a[0], 16);
        chk("t3_f2_a4", bus.win_a[4], 21);
        chk("t3_f2_a8", bus.win_a[8], 26);
      end
    end
    chk("t3_pulses", pulses, 8);

    // test 4: partial frame then sof restart
    for (int q = 0; q < 7; q++) step(1'b1, q == 0, q, 1'b0);
    pulses = 0;
    for (int q = 0; q < 16; q++) begin
      step(1'b1, q == 0, 100 + q, 1'b0);
      if (q == 10) begin
        chk("t4_a0", bus.win_a[0], 100);
        chk("t4_a8", bus.win_a[8], 110);
      end
    end
    chk("t4_pulses", pulses, 4);

    // test 5: reset mid-frame
    for (int q = 0; q < 10; q++) step(1'b1, q == 0, q, 1'b0);
    do_reset(1);
    pulses = 0;
    for (int q = 0; q < 16; q++) begin
      step(1'b1, 1'b0, q, 1'b0);
      if (q == 10) chk("t5_a8", bus.win_a[8], 10);
      if (q == 15) chk("t5_last", bus.win_last, 1);
    end
    chk("t5_pulses", pulses, 4);

    // randomized frames with stalls and gaps
    p      = 0;
    guard  = 0;
    pulses = 0;
    while (p < 16 * 4 && guard < 2000) begin
      v  = ($urandom % 4) != 0;
      st = ($urandom % 5) == 0;
      step(v, (p % 16) == 0, int'($urandom % 65536), st);
      if (v && !st) p++;
      guard++;
    end
    chk("rand_done", p, 16 * 4);
    step(1'b0, 1'b0, 0, 1'b0);
    chk("rand_pulses", pulses, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
